uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Byte FIFO feeding the UART transmitter (uart_tx) so user logic can queue bursts/strings
//  instead of hand-pacing single characters. Accepts bytes on a write strobe, stores up to
//  DEPTH entries, and drains them one at a time into uart_tx via a one-cycle tx_start pulse,
//  pacing on tx_busy. Sits between the top-level control FSM and uart_tx.
// PARAMETERS
//  DEPTH        16  FIFO entries; power of 2, >=2. ADDR_W = $clog2(DEPTH) (localparam)
//  BUSY_TIMEOUT 4   cycles to wait for tx_busy to rise after tx_start before giving up
// PORTS
//  sys_clk    in   1         clock
//  sys_rst_n  in   1         asynchronous, active-low reset
//  wr_data    in   8         byte to queue
//  wr_en      in   1         write strobe, sampled each rising edge
//  flush      in   1         synchronous clear of queued bytes
//  full       out  1         count == DEPTH
//  empty      out  1         count == 0
//  count      out  ADDR_W+1  bytes currently queued (not incl. byte in flight)
//  overflow   out  1         one-cycle pulse: write dropped because full
//  tx_start   out  1         one-cycle start pulse to uart_tx
//  tx_data    out  8         byte to uart_tx; stable from tx_start until next pop
//  tx_busy    in   1         uart_tx busy flag
// BEHAVIOUR
//  Reset (async): rd/wr pointers=0, count=0, empty=1, full=0, overflow=0, tx_start=0,
//   tx_data=8'h00, state=IDLE, timeout counter=0. Memory contents not reset.
//  Write: accepted iff wr_en && !full; mem[wr_ptr]<=wr_data, wr_ptr++ (wraps mod DEPTH).
//   wr_en && full: byte dropped, pointers/count unchanged, overflow=1 next cycle only.
//  Pop: only in IDLE when !empty && !tx_busy: tx_data<=mem[rd_ptr], rd_ptr++ (wraps),
//   tx_start<=1 for exactly one cycle, state->WAIT_BUSY.
//  Simultaneous accepted write + pop: both occur, count unchanged. Write into empty FIFO is
//   not popped the same edge (pop decision uses pre-edge count).
//  Latency: write accepted at edge N -> tx_start high after edge N+1 (FIFO idle, tx_busy=0).
//  count/full/empty are registered and consistent with pointers after every edge.
//  FSM:
//   IDLE      : pop condition met -> WAIT_BUSY (timer cleared)
//   WAIT_BUSY : tx_busy=1 -> WAIT_DONE; else timer++; timer==BUSY_TIMEOUT -> IDLE
//               (byte treated as sent; no retry)
//   WAIT_DONE : tx_busy=0 -> IDLE (next pop possible on following edge)
//  tx_busy high while IDLE (externally driven transmission): no pop until it falls.
//  Flush: count=0, rd_ptr=wr_ptr=0, empty=1 next cycle; wr_en in same cycle is ignored;
//   byte already handed to uart_tx is not aborted, FSM finishes normally.
//  Flush with FSM in IDLE and pop condition met same edge: flush wins, no tx_start.
//  Reset mid-transmission: FIFO emptied, tx_start=0 immediately; uart_tx resets alongside.
//  Throughput: at most one byte per uart_tx frame; FIFO never issues tx_start while
//   tx_busy=1 or while in WAIT_BUSY/WAIT_DONE.
// TESTING
//  1. Reset, write 8'h41 once, model uart_tx (busy 1 cycle after start, 10 bit-times) ->
//     tx_start single pulse 2 edges after write, tx_data=8'h41, empty=1 after pop.
//  2. Burst-write "HELLO" (5 bytes back-to-back) -> count peaks at 4-5, exactly 5
//     tx_start pulses in order 48,45,4C,4C,4F, each only after tx_busy fell.
//  3. Fill DEPTH=16 with tx_busy held 1, write 17th byte -> full=1, count=16, overflow
//     pulses one cycle, 17th byte never transmitted; release busy -> 16 bytes out in order.
//  4. Write 20 bytes over time with draining -> pointers wrap, output order == input order.
//  5. tx_busy never asserts after tx_start -> FSM returns IDLE after BUSY_TIMEOUT cycles,
//     next queued byte starts; flush with 3 queued + 1 in flight -> in-flight completes,
//     no further tx_start, count=0.
//  6. Assert sys_rst_n=0 mid-WAIT_DONE with 5 queued -> count=0, empty=1, tx_start=0
//     asynchronously; after release, no tx_start until new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that paces queued bytes into uart_tx
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [7:0]               wr_data,
    input  logic                     wr_en,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int TMR_W  = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [TMR_W-1:0]    timer_q;
    logic [TMR_W-1:0]    timer_d;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]    count_d;
    logic                push;
    logic                pop;
    logic [7:0]          mem [DEPTH];

    // Accept a write only when there is room; flush swallows any same-cycle write.
    assign push = wr_en && !full && !flush;

    // Pop decision, handshake sequencing with uart_tx and the busy-rise timeout.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !tx_busy && !flush) begin
                    pop     = 1'b1;
                    state_d = WAIT_BUSY;
                    timer_d = '0;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                    timer_d = '0;
                end else if (timer_q == TMR_W'(BUSY_TIMEOUT - 1)) begin
                    // uart_tx never acknowledged: treat the byte as sent, no retry
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Occupancy after this edge; flush overrides any concurrent push or pop.
    always_comb begin
        count_d = count;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Control state, pointers, registered flags and the outgoing byte.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            count    <= count_d;
            full     <= (count_d == CNT_W'(DEPTH));
            empty    <= (count_d == '0);
            overflow <= wr_en && full && !flush;
            tx_start <= pop;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end
            end
            if (pop) begin
                tx_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int DEPTH        = 16;
    localparam int BUSY_TIMEOUT = 4;
    localparam int FRAME        = 10;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  wr_data   = 8'h00;
    logic        wr_en     = 1'b0;
    logic        flush     = 1'b0;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic        overflow;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy   = 1'b0;

    uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .flush     (flush),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    bit          ovf_exp  = 0;
    bit          busy_hold = 0;
    bit          uart_dead = 0;
    int          busy_cnt = 0;
    int          cyc = 0;
    int          starts = 0;
    int          last_start_cyc = -100;
    bit          last_start_dead = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Monitor + uart_tx model: check outputs at the falling edge, then update busy.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            busy_cnt = 0;
            ovf_exp  = 0;
        end else begin
            if (tx_start) begin
                starts++;
                chk("busy_at_start", tx_busy, 0);
                chk("start_gap_min", (cyc - last_start_cyc) >= 2, 1);
                if (uart_dead && last_start_dead) begin
                    chk("timeout_gap", ((cyc - last_start_cyc) >= BUSY_TIMEOUT + 1) &&
                                       ((cyc - last_start_cyc) <= BUSY_TIMEOUT + 3), 1);
                end
                last_start_cyc  = cyc;
                last_start_dead = uart_dead;
                if (exp_q.size() == 0) begin
                    chk("unexpected_tx_start", 1, 0);
                end else begin
                    chk("tx_data", tx_data, exp_q.pop_front());
                end
                if (!uart_dead) busy_cnt = FRAME;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            chk("count", count, exp_q.size());
            chk("empty", empty, exp_q.size() == 0);
            chk("full", full, exp_q.size() == DEPTH);
            chk("overflow", overflow, ovf_exp);
            ovf_exp = 0;
        end
        tx_busy = busy_hold || (busy_cnt > 0);
    end

    task automatic write_byte(input logic [7:0] b);
        @(negedge sys_clk); #1;
        wr_en   = 1'b1;
        wr_data = b;
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else ovf_exp = 1;
        @(posedge sys_clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge sys_clk); #1;
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        exp_q.delete();
        @(posedge sys_clk); #1;
        flush = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || tx_busy) && k < 3000) begin
            @(negedge sys_clk);
            k++;
        end
        chk(name, k < 3000, 1);
        repeat (12) @(negedge sys_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] hello [5];
        int peak;
        int s0;
        hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C;
        hello[3] = 8'h4C; hello[4] = 8'h4F;

        // reset state
        repeat (3) @(negedge sys_clk);
        #1 sys_rst_n = 1'b1;
        #2;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 8'h00);

        // 1: single byte latency
        @(negedge sys_clk); #1;
        wr_en = 1'b1; wr_data = 8'h41; exp_q.push_back(8'h41);
        @(posedge sys_clk); #1;
        wr_en = 1'b0;
        chk("t1_no_start_yet", tx_start, 0);
        @(posedge sys_clk); #1;
        chk("t1_start", tx_start, 1);
        chk("t1_data", tx_data, 8'h41);
        chk("t1_empty", empty, 1);
        @(posedge sys_clk); #1;
        chk("t1_single_pulse", tx_start, 0);
        drain("t1_drain");

        // 2: HELLO burst
        s0 = starts;
        peak = 0;
        for (int i = 0; i < 5; i++) begin
            write_byte(hello[i]);
            if (count > peak) peak = count;
        end
        chk("t2_peak", (peak >= 4) && (peak <= 5), 1);
        drain("t2_drain");
        chk("t2_starts", starts - s0, 5);

        // 3: fill with busy held, overflow on 17th
        @(negedge sys_clk); #1 busy_hold = 1;
        repeat (2) @(negedge sys_clk);
        s0 = starts;
        for (int i = 0; i < DEPTH; i++) write_byte(8'(8'h60 + i));
        chk("t3_full", full, 1);
        chk("t3_count", count, DEPTH);
        write_byte(8'hFF);
        @(negedge sys_clk); #1;
        chk("t3_count_after_ovf", count, DEPTH);
        busy_hold = 0;
        drain("t3_drain");
        chk("t3_starts", starts - s0, DEPTH);

        // 4: 20 random bytes with random spacing, pointer wrap
        s0 = starts;
        for (int i = 0; i < 20; i++) begin
            write_byte(8'($urandom));
            repeat ($urandom_range(0, 12)) @(negedge sys_clk);
        end
        drain("t4_drain");
        chk("t4_starts", starts - s0, 20);

        // 5a: uart never acknowledges -> timeout then next byte
        @(negedge sys_clk); #1 uart_dead = 1;
        s0 = starts;
        write_byte(8'hA1);
        write_byte(8'hA2);
        drain("t5_timeout_drain");
        chk("t5_timeout_starts", starts - s0, 2);
        uart_dead = 0;

        // 5b: flush with 3 queued + 1 in flight
        s0 = starts;
        for (int i = 0; i < 4; i++) write_byte(8'(8'hB0 + i));
        chk("t5_count_before_flush", count, 3);
        do_flush();
        repeat (25) @(negedge sys_clk);
        #1;
        chk("t5_count_after_flush", count, 0);
        chk("t5_empty_after_flush", empty, 1);
        chk("t5_starts_after_flush", starts - s0, 1);

        // 6: reset in WAIT_DONE with 5 queued
        for (int i = 0; i < 6; i++) write_byte(8'(8'hC0 + i));
        repeat (3) @(negedge sys_clk);
        #1;
        chk("t6_busy_before_rst", tx_busy, 1);
        chk("t6_count_before_rst", count, 5);
        #1 sys_rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_rst_count", count, 0);
        chk("t6_rst_empty", empty, 1);
        chk("t6_rst_tx_start", tx_start, 0);
        repeat (2) @(negedge sys_clk);
        #1 sys_rst_n = 1'b1;
        s0 = starts;
        repeat (20) @(negedge sys_clk);
        chk("t6_no_start_after_rst", starts - s0, 0);
        write_byte(8'h5A);
        drain("t6_recover_drain");
        chk("t6_recover_starts", starts - s0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
